// File: rtl/cpu_defs.sv
// Shared CPU pipeline definitions used by the IF, ID and EX stages.
// Provides the data-path width, the reset PC/IM window base, the IM depth,
// the bubble instruction word and a helper that tests whether a PC falls
// inside the instruction-memory window.
package cpu_defs;

  localparam int unsigned WORD = 32;

  // Reset PC; also the base of the instruction-memory window.
  localparam logic [WORD-1:0] PC_RESET = 32'h0000_3000;

  // Instruction-memory depth in words.
  localparam int unsigned IM_WORDS = 1024;

  // Word loaded into a pipeline register when a bubble is inserted.
  localparam logic [WORD-1:0] NOP = 32'h0000_0000;

  // Window test: (pc - PC_RESET) < 4*IM_WORDS. The subtraction is unsigned
  // and wraps, so PCs below the base land far above the window span.
  function automatic logic in_im_window(input logic [WORD-1:0] pc);
    logic [WORD-1:0] offset;
    logic [WORD-1:0] span;
    offset = pc - PC_RESET;
    span   = WORD'(IM_WORDS) << 2;
    return offset < span;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / bubble control.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   bubble              replace instr with NOP and clear valid (pc fields hold)
//   load                capture the nxt_* fields (ignored while bubble)
//   nxt_instr/pc/pc8    incoming fields
//   nxt_valid           incoming valid flag
//   instr/pc/pc8/valid  registered fields
// With neither bubble nor load asserted every field holds.
module if_id_reg
  import cpu_defs::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            bubble,
  input  logic            load,
  input  logic [WORD-1:0] nxt_instr,
  input  logic [WORD-1:0] nxt_pc,
  input  logic [WORD-1:0] nxt_pc8,
  input  logic            nxt_valid,
  output logic [WORD-1:0] instr,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] pc8,
  output logic            valid
);

  logic [WORD-1:0] instr_q;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] pc8_q;
  logic            valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= '0;
      pc8_q   <= '0;
      valid_q <= 1'b0;
    end else if (bubble) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= nxt_instr;
      pc_q    <= nxt_pc;
      pc8_q   <= nxt_pc8;
      valid_q <= nxt_valid;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign pc8   = pc8_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, drives the IM address and captures the returned word into
// IF/ID. Redirects keep delay-slot semantics: the word fetched in the
// redirect cycle still enters IF/ID.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   stall               hold PC and IF/ID (redirect ignored while set)
//   flush               bubble IF/ID on the next edge (overrides stall)
//   redirect            ID resolved a taken branch / jump
//   redirect_pc         redirect target (low two bits dropped)
//   im_instr            IM word for im_pc (combinational read)
//   im_pc               current PC
//   id_instr/pc/pc8     IF/ID fields (pc8 = link value)
//   id_valid            IF/ID holds a real instruction
//   fetch_err           sticky misaligned-redirect / out-of-window flag
//   fetch_count         instructions accepted into IF/ID
module if_stage
  import cpu_defs::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  input  logic [WORD-1:0] im_instr,
  output logic [WORD-1:0] im_pc,
  output logic [WORD-1:0] id_instr,
  output logic [WORD-1:0] id_pc,
  output logic [WORD-1:0] id_pc8,
  output logic            id_valid,
  output logic            fetch_err,
  output logic [WORD-1:0] fetch_count
);

  logic [WORD-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [WORD-1:0] cnt_q, cnt_d;

  logic            in_window;
  logic            ifid_load;
  logic            redirect_take;
  logic [WORD-1:0] ifid_instr;

  assign in_window     = in_im_window(pc_q);
  assign redirect_take = redirect & ~stall;
  // Flush wins over stall inside if_id_reg; load only matters when not flushing.
  assign ifid_load     = ~stall & ~flush;
  assign ifid_instr    = in_window ? im_instr : NOP;

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    cnt_d = cnt_q;

    if (!stall) begin
      if (redirect) pc_d = {redirect_pc[WORD-1:2], 2'b00};
      else          pc_d = pc_q + 32'd4;
    end

    if (redirect_take && (redirect_pc[1:0] != 2'b00)) err_d = 1'b1;
    if (ifid_load && !in_window)                      err_d = 1'b1;

    if (ifid_load && in_window) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .bubble    (flush),
    .load      (~stall),
    .nxt_instr (ifid_instr),
    .nxt_pc    (pc_q),
    .nxt_pc8   (pc_q + 32'd8),
    .nxt_valid (in_window),
    .instr     (id_instr),
    .pc        (id_pc),
    .pc8       (id_pc8),
    .valid     (id_valid)
  );

  assign im_pc       = pc_q;
  assign fetch_err   = err_q;
  assign fetch_count = cnt_q;

endmodule
